// File: rtl/decoder_pkg.sv
// Shared types and widths for the registered 3-to-8 decoder.
// Holds the FSM state enum and the code, output and counter widths.
package decoder_pkg;

  localparam int CODE_W = 3;
  localparam int OUT_W  = 8;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    GAP
  } state_t;

endpackage

// File: rtl/decoder3_8_seq_pulse_timer.sv
// pulse_timer: loadable down-counter shared by the ACTIVE and GAP states.
// Ports: load/load_val reload, dec steps down (holds at 0), value, zero flag.
module pulse_timer
  import decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/decoder3_8_seq.sv
// Registered 3-to-8 decoder: valid/ready input, timed one-hot pulse on y,
// then a quiet gap. Ports: clk, rst_n, in_valid/in_ready/in_code, y, busy,
// done; with DEC_PARITY_EN also in_parity (even parity) and err.
module decoder3_8_seq
  import decoder_pkg::*;
#(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic [OUT_W-1:0]  y,
  output logic              busy,
  output logic              done
`ifdef DEC_PARITY_EN
  ,
  input  logic              in_parity,
  output logic              err
`endif
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  state_t              state_q, state_n;
  logic [CODE_W-1:0]   code_q, code_n;
  logic                ld;
  logic [CNT_W-1:0]    ld_val;
  logic                dec;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_n;
  logic                cnt_zero;
  logic [OUT_W-1:0]    y_n;
  logic                rdy_n;
  logic                done_n;
`ifdef DEC_PARITY_EN
  logic                err_n;
`endif

  pulse_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .load_val (ld_val),
    .dec      (dec),
    .value    (cnt),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_n = state_q;
    code_n  = code_q;
    ld      = 1'b0;
    ld_val  = '0;
    dec     = 1'b0;
`ifdef DEC_PARITY_EN
    err_n   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef DEC_PARITY_EN
        if (in_valid && ^{in_code, in_parity}) begin
          err_n = 1'b1;
        end else if (in_valid) begin
`else
        if (in_valid) begin
`endif
          state_n = ACTIVE;
          code_n  = in_code;
          ld      = 1'b1;
          ld_val  = PULSE_LD;
        end
      end
      ACTIVE: begin
        if (cnt_zero) begin
          if (GAP_CYCLES == 0) begin
            state_n = IDLE;
          end else begin
            state_n = GAP;
            ld      = 1'b1;
            ld_val  = GAP_LD;
          end
        end else begin
          dec = 1'b1;
        end
      end
      GAP: begin
        if (cnt_zero) state_n = IDLE;
        else          dec     = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are computed from next state/count so they land in flops
  // aligned with the state they describe.
  always_comb begin
    cnt_n  = ld ? ld_val : (dec ? cnt - 1'b1 : cnt);
    rdy_n  = (state_n == IDLE);
    done_n = (state_n == ACTIVE) && (cnt_n == '0);
    y_n    = (state_n == ACTIVE) ? (OUT_W'(1) << code_n) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      y        <= '0;
      in_ready <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      code_q   <= code_n;
      y        <= y_n;
      in_ready <= rdy_n;
      busy     <= !rdy_n;
      done     <= done_n;
    end
  end

`ifdef DEC_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= err_n;
  end
`endif

endmodule

// File: tb/tb_decoder3_8_seq.sv
// Scoreboard bench for decoder3_8_seq: driver pushes accepted codes,
// a negedge monitor pops them and checks pulse shape and timing.
module tb_decoder3_8_seq;

  localparam int P = 4;
  localparam int G = 1;

  typedef struct {
    logic [2:0] code;
    int         t;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_code = 3'd0;
  logic [7:0] y;
  logic       busy;
  logic       done;
`ifdef DEC_PARITY_EN
  logic       in_parity = 1'b0;
  logic       err;
`endif

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 0;
  bit    cur_v = 0;
  int    cur_start = 0;
  int    cur_code = 0;
  item_t sb[$];

  decoder3_8_seq #(
    .PULSE_CYCLES (P),
    .GAP_CYCLES   (G)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_code  (in_code),
    .y        (y),
    .busy     (busy),
    .done     (done)
`ifdef DEC_PARITY_EN
    ,
    .in_parity(in_parity),
    .err      (err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Monitor: expected outputs derived from the accepted code and the
  // handshake cycle using the pulse/gap lengths only.
  initial begin
    item_t it;
    int    k;
    int    ey;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_v = 0;
        sb.delete();
        chk("reset y", 32'(y), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
      end else if (mon_en) begin
        chk("onehot", 32'($countones(y) <= 1), 32'd1);
        if (!cur_v && sb.size() > 0 &&
            (y != 8'd0 || cyc >= sb[0].t + 1)) begin
          it = sb.pop_front();
          cur_v = 1;
          cur_code = int'(it.code);
          cur_start = it.t + 1;
        end
        if (cur_v) begin
          k  = cyc - cur_start;
          ey = (k < P) ? 2 ** cur_code : 0;
          chk("y", 32'(y), 32'(ey));
          chk("done", 32'(done), 32'(k == P - 1));
          chk("busy", 32'(busy), 32'(k < P + G));
          chk("in_ready", 32'(in_ready), 32'(k >= P + G));
          if (k >= P + G - 1) cur_v = 0;
        end else begin
          chk("idle y", 32'(y), 32'd0);
          chk("idle done", 32'(done), 32'd0);
          chk("idle busy", 32'(busy), 32'd0);
          chk("idle in_ready", 32'(in_ready), 32'd1);
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after the transfer edge.
  task automatic send(input logic [2:0] c, input bit bad, input bit keep);
    int    n = 0;
    item_t it;
    in_valid = 1'b1;
    in_code  = c;
`ifdef DEC_PARITY_EN
    in_parity = (^c) ^ bad;
`endif
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      timeout("handshake");
      in_valid = 1'b0;
      return;
    end
`ifdef DEC_PARITY_EN
    if (!bad) begin
      it.code = c;
      it.t = cyc;
      sb.push_back(it);
    end
`else
    it.code = c;
    it.t = cyc;
    sb.push_back(it);
`endif
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
`ifdef DEC_PARITY_EN
    if (bad) begin
      chk("err pulse", 32'(err), 32'd1);
      chk("reject y", 32'(y), 32'd0);
      chk("reject in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      chk("err clears", 32'(err), 32'd0);
    end
`endif
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || cur_v) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("drain");
  endtask

  initial begin
    logic [2:0] c;
    bit         bad;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", 32'(in_ready), 32'd1);
    mon_en = 1;

    // basic pulse
    send(3'd5, 1'b0, 1'b0);
    drain();
    @(negedge clk);

    // full sweep, valid held high
    for (int i = 0; i < 8; i++) send(3'(i), 1'b0, 1'b1);
    in_valid = 1'b0;
    drain();
    @(negedge clk);

    // valid while busy is ignored
    send(3'd6, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_code  = 3'd2;
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    @(negedge clk);

    // reset in 2nd cycle of a code-7 pulse
    send(3'd7, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset y", 32'(y), 32'd0);
    chk("async reset done", 32'(done), 32'd0);
    chk("async reset busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after mid reset", 32'(in_ready), 32'd1);

`ifdef DEC_PARITY_EN
    send(3'b011, 1'b1, 1'b0);
    send(3'b011, 1'b0, 1'b0);
    @(negedge clk);
    chk("parity accept y", 32'(y), 32'h08);
    drain();
    @(negedge clk);
`endif

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      c   = 3'($urandom_range(0, 7));
      bad = ($urandom_range(0, 5) == 0);
`ifndef DEC_PARITY_EN
      bad = 1'b0;
`endif
      send(c, bad, ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    drain();
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
